imem_boot_loader: RTL and testbench

//  Writer side of the instruction-memory port the unicycle core fetches from. Receives a framed

---
 rtl/imem_boot_loader_pkg.sv | 28 ++
 rtl/imem_boot_loader_if.sv | 32 +++
 rtl/imem_boot_loader_byte_packer.sv | 68 ++++++
 rtl/imem_boot_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    // Loader sequencing: framing header, payload, trailing checksum, outcome.
    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_e;

    // Width of the little-endian word count in the frame header.
    localparam int LEN_WIDTH = 16;

    // Default instruction width of the unicycle core.
    localparam int DEF_DATA_WIDTH = 20;

    // Bytes needed to carry one instruction; the last byte may carry unused high bits.
    function automatic int bytes_per_word(input int data_width);
        return (data_width + 7) / 8;
    endfunction

    localparam int BPW = bytes_per_word(DEF_DATA_WIDTH);

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host byte link (valid/ready) plus the imem write port, bundled for the loader.
interface imem_boot_loader_if #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    // Host / memory-model side: supplies bytes, observes handshake and writes.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side: consumes bytes, drives the imem write port.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs a stream of accepted bytes into little-endian instruction words.
// Emits the finished word and a one-cycle word_valid in the cycle after its last byte.
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BYTES      = BPW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  last_byte,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);
    localparam int CNT_W   = $clog2(BYTES);
    localparam int SHIFT_W = (BYTES - 1) * 8;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  word_valid_q, word_valid_d;

    assign last_byte  = byte_valid && (cnt_q == CNT_W'(BYTES - 1));
    assign word       = word_q;
    assign word_valid = word_valid_q;

    // Next-state: advance the byte counter, shift earlier bytes down, assemble on the last byte.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            if (last_byte) begin
                cnt_d        = '0;
                // Earlier bytes already sit low; bits beyond DATA_WIDTH are dropped here.
                word_d       = DATA_WIDTH'({byte_data, shift_q});
                word_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            shift_d = {byte_data, shift_q[SHIFT_W-1:8]};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Writer side of the core's instruction memory: parses a framed byte stream from the
// host, writes packed instructions sequentially and releases the core only after a
// load whose checksum matches.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256,
    parameter bit BOOT_HOLD     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    imem_boot_loader_if.slave      bus,
    output logic                   core_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDRESS_WIDTH:0] words_loaded
);
    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);

    typedef logic [ADDRESS_WIDTH:0] count_t;

    state_e                   state_q, state_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [7:0]               chk_q, chk_d;
    count_t                   words_q, words_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     core_rst_n_q, core_rst_n_d;

    logic                  load_state;
    logic                  byte_fire;
    logic                  packer_clear;
    logic                  last_byte;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;

    // Ready/busy are pure decodes of the state register.
    assign load_state = (state_q inside {LEN_LO, LEN_HI, DATA, CHECK});
    assign byte_fire  = bus.in_valid && load_state;

    assign bus.in_ready  = load_state;
    assign busy          = load_state;
    assign bus.mem_we    = word_valid;
    assign bus.mem_wdata = word;
    assign bus.mem_addr  = mem_addr_q;
    assign core_rst_n    = core_rst_n_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_loaded  = words_q;

    imem_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTES      (BYTES_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .byte_valid (byte_fire && (state_q == DATA)),
        .byte_data  (bus.in_data),
        .last_byte  (last_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    // Frame parser: header length check, payload word counting, checksum verdict.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        chk_d        = chk_q;
        words_d      = words_q;
        mem_addr_d   = mem_addr_q;
        done_d       = done_q;
        error_d      = error_q;
        core_rst_n_d = core_rst_n_q;
        packer_clear = 1'b0;

        // The write cycle of a word retires it; a reload below overrides this.
        if (word_valid) begin
            words_d = words_q + count_t'(1);
        end

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d      = LEN_LO;
                    len_d        = '0;
                    chk_d        = '0;
                    words_d      = '0;
                    mem_addr_d   = '0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    core_rst_n_d = 1'b0;
                    packer_clear = 1'b1;
                end
            end
            LEN_LO: begin
                if (byte_fire) begin
                    len_d   = {8'h00, bus.in_data};
                    chk_d   = chk_q ^ bus.in_data;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (byte_fire) begin
                    len_d = {bus.in_data, len_q[7:0]};
                    chk_d = chk_q ^ bus.in_data;
                    if ({16'd0, len_d} > 32'(MEM_SIZE)) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else if (len_d == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_fire) begin
                    chk_d = chk_q ^ bus.in_data;
                    if (last_byte) begin
                        // Word index is the count of words retired before this one.
                        mem_addr_d = words_q[ADDRESS_WIDTH-1:0];
                        if (LEN_WIDTH'(words_q) + LEN_WIDTH'(1) == len_q) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (byte_fire) begin
                    if (bus.in_data == chk_q) begin
                        state_d      = DONE;
                        done_d       = 1'b1;
                        core_rst_n_d = 1'b1;
                    end else begin
                        state_d      = ERROR;
                        error_d      = 1'b1;
                        core_rst_n_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single register bank for the FSM and all of its registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            chk_q        <= '0;
            words_q      <= '0;
            mem_addr_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= ~BOOT_HOLD;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            chk_q        <= chk_d;
            words_q      <= words_d;
            mem_addr_q   <= mem_addr_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a table of whole frames plus hand-written
// sequences for the length boundary and reset in the middle of a load.
module tb_imem_boot_loader;

    localparam int DW = 20;
    localparam int AW = 8;

    typedef struct {
        string      name;
        int         nbytes;
        logic [7:0] bytes [12];
        bit         gaps;
        int         start_at;
        bit         exp_done;
        bit         exp_error;
        int         exp_words;
        int         exp_nwr;
        logic [19:0] exp_wdata [3];
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          core_rst_n, busy, done, error;
    logic [AW:0]   words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];

    vec_t vecs [5];

    imem_boot_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    imem_boot_loader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .MEM_SIZE      (256),
        .BOOT_HOLD     (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .core_rst_n   (core_rst_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   32'(bus.in_ready),  0);
        check({tag, "_mem_we"},     32'(bus.mem_we),    0);
        check({tag, "_mem_addr"},   32'(bus.mem_addr),  0);
        check({tag, "_mem_wdata"},  32'(bus.mem_wdata), 0);
        check({tag, "_busy"},       32'(busy),          0);
        check({tag, "_done"},       32'(done),          0);
        check({tag, "_error"},      32'(error),         0);
        check({tag, "_words"},      32'(words_loaded),  0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n),    0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte and hold it until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("byte_handshake_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_frame_a_good();
        logic [7:0] fa [9];
        fa = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06, 8'h25};
        for (int k = 0; k < 9; k++) send_byte(fa[k]);
    endtask

    initial begin
        vec_t v;
        int   waited;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Frame A: 2 words, checksum 02^00^11^22^03^44^55^06 = 0x25.
        vecs[0].name = "good_2w"; vecs[0].nbytes = 9; vecs[0].gaps = 0; vecs[0].start_at = -1;
        vecs[0].bytes = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06, 8'h25, 8'h00, 8'h00, 8'h00};
        vecs[0].exp_done = 1; vecs[0].exp_error = 0; vecs[0].exp_words = 2; vecs[0].exp_nwr = 2;
        vecs[0].exp_wdata = '{20'h32211, 20'h65544, 20'h00000};

        vecs[1].name = "bad_chk"; vecs[1].nbytes = 9; vecs[1].gaps = 0; vecs[1].start_at = -1;
        vecs[1].bytes = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55, 8'h06, 8'h26, 8'h00, 8'h00, 8'h00};
        vecs[1].exp_done = 0; vecs[1].exp_error = 1; vecs[1].exp_words = 2; vecs[1].exp_nwr = 2;
        vecs[1].exp_wdata = '{20'h32211, 20'h65544, 20'h00000};

        // N = 0x0101 = 257 exceeds MEM_SIZE: fails right after LEN_HI.
        vecs[2].name = "too_long"; vecs[2].nbytes = 2; vecs[2].gaps = 0; vecs[2].start_at = -1;
        vecs[2].bytes = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].exp_done = 0; vecs[2].exp_error = 1; vecs[2].exp_words = 0; vecs[2].exp_nwr = 0;
        vecs[2].exp_wdata = '{20'h00000, 20'h00000, 20'h00000};

        vecs[3].name = "zero_len"; vecs[3].nbytes = 3; vecs[3].gaps = 0; vecs[3].start_at = -1;
        vecs[3].bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].exp_done = 1; vecs[3].exp_error = 0; vecs[3].exp_words = 0; vecs[3].exp_nwr = 0;
        vecs[3].exp_wdata = '{20'h00000, 20'h00000, 20'h00000};

        // 3 words with idle gaps, 0xF3 top byte, stray start mid-DATA; checksum 0x5E.
        vecs[4].name = "gaps_f3"; vecs[4].nbytes = 12; vecs[4].gaps = 1; vecs[4].start_at = 6;
        vecs[4].bytes = '{8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h02, 8'h03, 8'hDE, 8'hAD, 8'hF3, 8'h5E};
        vecs[4].exp_done = 1; vecs[4].exp_error = 0; vecs[4].exp_words = 3; vecs[4].exp_nwr = 3;
        vecs[4].exp_wdata = '{20'hCBBAA, 20'h30201, 20'h3ADDE};

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Bytes offered while idle are neither accepted nor written.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        check("idle_no_writes", 32'(wr_addr_q.size()), 0);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            clear_log();
            pulse_start();
            check({v.name, "_start_busy"},       32'(busy),         1);
            check({v.name, "_start_core_rst_n"}, 32'(core_rst_n),   0);
            check({v.name, "_start_words"},      32'(words_loaded), 0);
            check({v.name, "_start_flags"},      32'({done, error}), 0);
            for (int b = 0; b < v.nbytes; b++) begin
                if (v.gaps && b > 0) repeat ($urandom_range(0, 3)) @(posedge clk);
                if (b == v.start_at) pulse_start();
                send_byte(v.bytes[b]);
            end
            waited = 0;
            @(negedge clk);
            while (busy && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check({v.name, "_settle_cycles"}, 32'(waited),         0);
            check({v.name, "_done"},          32'(done),           32'(v.exp_done));
            check({v.name, "_error"},         32'(error),          32'(v.exp_error));
            check({v.name, "_core_rst_n"},    32'(core_rst_n),     32'(v.exp_done));
            check({v.name, "_words"},         32'(words_loaded),   32'(v.exp_words));
            check({v.name, "_in_ready"},      32'(bus.in_ready),   0);
            check({v.name, "_nwrites"},       32'(wr_addr_q.size()), 32'(v.exp_nwr));
            for (int w = 0; w < v.exp_nwr; w++) begin
                if (w < wr_addr_q.size()) begin
                    check({v.name, "_waddr"}, 32'(wr_addr_q[w]), 32'(w));
                    check({v.name, "_wdata"}, 32'(wr_data_q[w]), 32'(v.exp_wdata[w]));
                end
            end
        end

        // N = 256 exactly is accepted: the loader stays busy in DATA.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        @(negedge clk);
        check("len256_busy",     32'(busy),         1);
        check("len256_error",    32'(error),        0);
        check("len256_in_ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        #2;
        check_reset_outputs("len256_abort");
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-DATA after one full word and one partial byte.
        clear_log();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h03); send_byte(8'h44);
        rst = 1'b0;
        #2;
        check_reset_outputs("mid_data_rst");
        check("mid_data_rst_writes", 32'(wr_addr_q.size()), 1);
        @(negedge clk);
        rst = 1'b1;

        // Fresh load afterwards starts from address 0 with a clean packer.
        clear_log();
        pulse_start();
        send_frame_a_good();
        @(negedge clk);
        check("reload_done",       32'(done),       1);
        check("reload_core_rst_n", 32'(core_rst_n), 1);
        check("reload_words",      32'(words_loaded), 2);
        check("reload_nwrites",    32'(wr_addr_q.size()), 2);
        if (wr_addr_q.size() == 2) begin
            check("reload_addr0", 32'(wr_addr_q[0]), 0);
            check("reload_data0", 32'(wr_data_q[0]), 32'h32211);
            check("reload_addr1", 32'(wr_addr_q[1]), 1);
            check("reload_data1", 32'(wr_data_q[1]), 32'h65544);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
